// File: rtl/tl_mem_responder.sv
// tl_mem_responder: TileLink-UH manager endpoint backed by a 64-bit register-file memory.
// Serves Get/PutFull/PutPartial/Hint with bursts up to 64 B; Arith/Logical, Acquire
// opcodes and out-of-window addresses are answered with denied responses.
// Optional feature macro: TL_RESP_DELAY_EN inserts a WAIT state of RESP_DELAY cycles
// before the first D beat of every response.
module tl_mem_responder #(
  parameter int unsigned DEPTH      = 1024,
  parameter logic [32:0] BASE       = 33'h0_8000_0000,
  parameter int unsigned RESP_DELAY = 2
) (
  input  logic        clock,
  input  logic        reset,
  output logic        a_ready_o,
  input  logic        a_valid_i,
  input  logic [2:0]  a_opcode_i,
  input  logic [2:0]  a_param_i,
  input  logic [2:0]  a_size_i,
  input  logic [5:0]  a_source_i,
  input  logic [32:0] a_address_i,
  input  logic [7:0]  a_mask_i,
  input  logic [63:0] a_data_i,
  input  logic        d_ready_i,
  output logic        d_valid_o,
  output logic [2:0]  d_opcode_o,
  output logic [2:0]  d_size_o,
  output logic [5:0]  d_source_o,
  output logic        d_denied_o,
  output logic [63:0] d_data_o,
  output logic        idle_o
);

  localparam int unsigned AW      = $clog2(DEPTH);
  localparam int unsigned TAG_LSB = AW + 3;

  localparam logic [2:0] OP_PUTF  = 3'd0;
  localparam logic [2:0] OP_PUTP  = 3'd1;
  localparam logic [2:0] OP_ARITH = 3'd2;
  localparam logic [2:0] OP_LOGIC = 3'd3;
  localparam logic [2:0] OP_GET   = 3'd4;
  localparam logic [2:0] OP_HINT  = 3'd5;

  localparam logic [2:0] D_ACK     = 3'd0;
  localparam logic [2:0] D_ACKDATA = 3'd1;
  localparam logic [2:0] D_HINTACK = 3'd2;

  typedef enum logic [2:0] {S_IDLE, S_WRITE, S_RESP, S_READ, S_WAIT} state_e;

  state_e          state_q, state_d;
  logic [2:0]      size_q, size_d;
  logic [5:0]      source_q, source_d;
  logic [AW-1:0]   word_q, word_d;
  logic            denied_q, denied_d;
  logic [2:0]      beat_q, beat_d;
  logic [2:0]      d_opcode_q, d_opcode_d;
  logic            d_valid_q, d_valid_d;
  logic            a_ready_q, a_ready_d;
  logic            idle_q, idle_d;
`ifdef TL_RESP_DELAY_EN
  state_e          tgt_q, tgt_d;
  logic [7:0]      cnt_q, cnt_d;
`endif

  logic [63:0]     mem [DEPTH];

  logic            a_fire_c, d_fire_c, in_range_c, req_denied_c, is_put_c;
  logic            enter_resp_c, enter_read_c, wr_en_c;
  logic [AW-1:0]   rd_idx_c, wr_idx_c;
  logic            unused_c;

  // Index of the last beat of a burst of 2^size bytes over 8-byte beats
  function automatic logic [2:0] last_beat(input logic [2:0] size);
    return (size > 3'd3) ? 3'((5'd1 << (size - 3'd3)) - 5'd1) : 3'd0;
  endfunction

  assign a_fire_c     = a_valid_i & a_ready_q;
  assign d_fire_c     = d_valid_q & d_ready_i;
  assign in_range_c   = (a_address_i[32:TAG_LSB] == BASE[32:TAG_LSB]);
  assign is_put_c     = (a_opcode_i == OP_PUTF) || (a_opcode_i == OP_PUTP);
  assign req_denied_c = !in_range_c ||
                        (a_opcode_i inside {OP_ARITH, OP_LOGIC, 3'd6, 3'd7});

  // Burst bases are size-aligned, so OR-ing the beat number into the word index is exact
  assign rd_idx_c = word_q | AW'(beat_q);
  assign wr_idx_c = (state_q == S_IDLE) ? a_address_i[TAG_LSB-1:3] : rd_idx_c;
  assign wr_en_c  = !reset && a_fire_c &&
                    (((state_q == S_IDLE) && is_put_c && !req_denied_c) ||
                     ((state_q == S_WRITE) && !denied_q));

  assign a_ready_o  = a_ready_q;
  assign d_valid_o  = d_valid_q;
  assign d_opcode_o = d_opcode_q;
  assign d_size_o   = size_q;
  assign d_source_o = source_q;
  assign d_denied_o = denied_q;
  assign idle_o     = idle_q;
  assign d_data_o   = ((d_opcode_q == D_ACKDATA) && !denied_q) ? mem[rd_idx_c] : 64'd0;

`ifdef TL_RESP_DELAY_EN
  assign unused_c = ^{a_param_i, a_address_i[2:0]};
`else
  assign unused_c = ^{a_param_i, a_address_i[2:0], 8'(RESP_DELAY)};
`endif

  // Next-state and registered-output decode
  always_comb begin
    state_d      = state_q;
    size_d       = size_q;
    source_d     = source_q;
    word_d       = word_q;
    denied_d     = denied_q;
    beat_d       = beat_q;
    d_opcode_d   = d_opcode_q;
    enter_resp_c = 1'b0;
    enter_read_c = 1'b0;
`ifdef TL_RESP_DELAY_EN
    tgt_d        = tgt_q;
    cnt_d        = cnt_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (a_fire_c) begin
          size_d   = a_size_i;
          source_d = a_source_i;
          word_d   = a_address_i[TAG_LSB-1:3];
          denied_d = req_denied_c;
          beat_d   = 3'd0;
          if (is_put_c) begin
            d_opcode_d = D_ACK;
            if (last_beat(a_size_i) != 3'd0) begin
              state_d = S_WRITE;
              beat_d  = 3'd1;
            end else begin
              enter_resp_c = 1'b1;
            end
          end else if (a_opcode_i == OP_GET) begin
            d_opcode_d   = D_ACKDATA;
            enter_read_c = 1'b1;
          end else if (a_opcode_i == OP_HINT) begin
            d_opcode_d   = D_HINTACK;
            enter_resp_c = 1'b1;
          end else begin
            d_opcode_d   = D_ACKDATA;
            enter_resp_c = 1'b1;
          end
        end
      end
      S_WRITE: begin
        if (a_fire_c) begin
          if (beat_q == last_beat(size_q)) begin
            beat_d       = 3'd0;
            enter_resp_c = 1'b1;
          end else begin
            beat_d = beat_q + 3'd1;
          end
        end
      end
      S_RESP, S_READ: begin
        if (d_fire_c) begin
          if ((d_opcode_q != D_ACKDATA) || (beat_q == last_beat(size_q))) begin
            state_d = S_IDLE;
            beat_d  = 3'd0;
          end else begin
            beat_d = beat_q + 3'd1;
          end
        end
      end
`ifdef TL_RESP_DELAY_EN
      S_WAIT: begin
        if (cnt_q == 8'd0) state_d = tgt_q;
        else               cnt_d   = cnt_q - 8'd1;
      end
`endif
      default: state_d = S_IDLE;
    endcase

    if (enter_resp_c || enter_read_c) begin
`ifdef TL_RESP_DELAY_EN
      if (RESP_DELAY != 0) begin
        state_d = S_WAIT;
        tgt_d   = enter_read_c ? S_READ : S_RESP;
        cnt_d   = 8'(RESP_DELAY - 1);
      end else
`endif
      state_d = enter_read_c ? S_READ : S_RESP;
    end

    d_valid_d = (state_d == S_RESP) || (state_d == S_READ);
    a_ready_d = (state_d == S_IDLE) || (state_d == S_WRITE);
    idle_d    = (state_d == S_IDLE);
  end

  // State and request-field registers
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= S_IDLE;
      size_q     <= 3'd0;
      source_q   <= 6'd0;
      word_q     <= '0;
      denied_q   <= 1'b0;
      beat_q     <= 3'd0;
      d_opcode_q <= 3'd0;
      d_valid_q  <= 1'b0;
      a_ready_q  <= 1'b1;
      idle_q     <= 1'b1;
`ifdef TL_RESP_DELAY_EN
      tgt_q      <= S_IDLE;
      cnt_q      <= 8'd0;
`endif
    end else begin
      state_q    <= state_d;
      size_q     <= size_d;
      source_q   <= source_d;
      word_q     <= word_d;
      denied_q   <= denied_d;
      beat_q     <= beat_d;
      d_opcode_q <= d_opcode_d;
      d_valid_q  <= d_valid_d;
      a_ready_q  <= a_ready_d;
      idle_q     <= idle_d;
`ifdef TL_RESP_DELAY_EN
      tgt_q      <= tgt_d;
      cnt_q      <= cnt_d;
`endif
    end
  end

  // Byte-lane masked memory write; contents survive reset
  always_ff @(posedge clock) begin
    if (wr_en_c) begin
      for (int i = 0; i < 8; i++) begin
        if (a_mask_i[i]) mem[wr_idx_c][8*i +: 8] <= a_data_i[8*i +: 8];
      end
    end
  end

`ifndef SYNTHESIS
  // Acquire opcodes are not legal at this endpoint
  always_ff @(posedge clock) begin
    if (!reset && a_fire_c && (state_q == S_IDLE)) begin
      assert ((a_opcode_i != 3'd6) && (a_opcode_i != 3'd7));
    end
  end
`endif

endmodule
